// File: rtl/msk_frame_sync_if.sv
// Bit-stream and frame-output bundle of the MSK frame synchronizer.
// Master drives the sliced bits; slave is the synchronizer.
interface msk_frame_sync_if #(
  parameter int EW = 6
) ();
  logic          data_i;
  logic          data_val_i;
  logic          hunt_i;
  logic [7:0]    byte_o;
  logic          byte_val_o;
  logic          sof_o;
  logic          eof_o;
  logic          lock_o;
  logic          inverted_o;
  logic          sync_det_o;
  logic [EW-1:0] sync_err_o;
  logic [15:0]   frame_cnt_o;

  modport master (
    output data_i,
    output data_val_i,
    output hunt_i,
    input  byte_o,
    input  byte_val_o,
    input  sof_o,
    input  eof_o,
    input  lock_o,
    input  inverted_o,
    input  sync_det_o,
    input  sync_err_o,
    input  frame_cnt_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    input  hunt_i,
    output byte_o,
    output byte_val_o,
    output sof_o,
    output eof_o,
    output lock_o,
    output inverted_o,
    output sync_det_o,
    output sync_err_o,
    output frame_cnt_o
  );
endinterface

// File: rtl/msk_frame_sync.sv
// MSK frame synchronizer: tolerant sync-word hunt with polarity
// resolution, then fixed-length MSB-first payload byte output.
module msk_frame_sync #(
  parameter int                SYNC_W        = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_W'(32'h1ACF_FC1D),
  parameter int                MAX_ERR       = 2,
  parameter int                PAYLOAD_BYTES = 16,
  parameter int                EW            = $clog2(SYNC_W+1)
) (
  input logic             clk,
  input logic             reset_n,
  msk_frame_sync_if.slave bus
);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam logic [EW-1:0] MAX_E  = EW'(MAX_ERR);
  localparam logic [EW-1:0] FULL   = EW'(SYNC_W);
  localparam logic [7:0]    LAST_B = 8'(PAYLOAD_BYTES-1);

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sr_q, sr_d;
  logic [EW-1:0]     fill_q, fill_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        byte_q, byte_d;
  logic              bval_q, bval_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              lock_q, lock_d;
  logic              inv_q, inv_d;
  logic              det_q, det_d;
  logic [EW-1:0]     err_q, err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic [SYNC_W-1:0] sr_nx;
  logic [EW-1:0]     fill_nx;
  logic [EW-1:0]     d0, d1;
  logic              armed, m0, m1;
  logic [7:0]        acc_nx;

  function automatic logic [EW-1:0] popcnt(
    input logic [SYNC_W-1:0] v
  );
    logic [EW-1:0] c;
    c = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      c = c + EW'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    sr_nx   = {sr_q[SYNC_W-2:0], bus.data_i};
    fill_nx = (fill_q == FULL) ? fill_q
                               : fill_q + EW'(1);
    armed   = (fill_nx == FULL);
    d0      = popcnt(sr_nx ^ SYNC_WORD);
    d1      = popcnt(sr_nx ^ ~SYNC_WORD);
    m0      = armed && (d0 <= MAX_E);
    m1      = armed && (d1 <= MAX_E);
    acc_nx  = {acc_q[6:0], bus.data_i ^ inv_q};
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    bit_d       = bit_q;
    bcnt_d      = bcnt_q;
    acc_d       = acc_q;
    byte_d      = byte_q;
    bval_d      = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    lock_d      = lock_q;
    inv_d       = inv_q;
    det_d       = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    // abort wins over a coincident bit, which is dropped unshifted
    if (bus.hunt_i) begin
      state_d = HUNT;
      fill_d  = '0;
      bit_d   = '0;
      bcnt_d  = '0;
      acc_d   = '0;
      lock_d  = 1'b0;
    end else if (bus.data_val_i) begin
      sr_d = sr_nx;
      unique case (1'b1)
        (state_q == HUNT): begin
          fill_d = fill_nx;
          if (m0 || m1) begin
            state_d = PAYLOAD;
            lock_d  = 1'b1;
            det_d   = 1'b1;
            inv_d   = !m0;
            err_d   = m0 ? d0 : d1;
            bit_d   = '0;
            bcnt_d  = '0;
            acc_d   = '0;
          end
        end
        (state_q == PAYLOAD): begin
          acc_d = acc_nx;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = acc_nx;
            bval_d = 1'b1;
            sof_d  = (bcnt_q == 8'd0);
            eof_d  = (bcnt_q == LAST_B);
            bcnt_d = bcnt_q + 8'd1;
            if (bcnt_q == LAST_B) begin
              state_d     = HUNT;
              lock_d      = 1'b0;
              fill_d      = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      bit_q       <= '0;
      bcnt_q      <= '0;
      acc_q       <= '0;
      byte_q      <= '0;
      bval_q      <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      lock_q      <= 1'b0;
      inv_q       <= 1'b0;
      det_q       <= 1'b0;
      err_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      bit_q       <= bit_d;
      bcnt_q      <= bcnt_d;
      acc_q       <= acc_d;
      byte_q      <= byte_d;
      bval_q      <= bval_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      lock_q      <= lock_d;
      inv_q       <= inv_d;
      det_q       <= det_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.byte_o      = byte_q;
  assign bus.byte_val_o  = bval_q;
  assign bus.sof_o       = sof_q;
  assign bus.eof_o       = eof_q;
  assign bus.lock_o      = lock_q;
  assign bus.inverted_o  = inv_q;
  assign bus.sync_det_o  = det_q;
  assign bus.sync_err_o  = err_q;
  assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Bench for msk_frame_sync: queue-based frame model checked every
// cycle, plus literal per-scenario expectations.
module tb_msk_frame_sync;

  localparam int          SW  = 32;
  localparam logic [31:0] ASM = 32'h1ACF_FC1D;
  localparam int          ME  = 2;
  localparam int          PB  = 16;
  localparam int          EW  = 6;
  localparam logic [39:0] PRE = 40'hA5_3C_96_0F_E1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  msk_frame_sync_if #(.EW(EW)) bus ();

  msk_frame_sync #(
    .SYNC_W(SW),
    .SYNC_WORD(ASM),
    .MAX_ERR(ME),
    .PAYLOAD_BYTES(PB),
    .EW(EW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // model
  bit            m_lock, m_inv;
  bit            hist[$];
  bit            pay[$];
  logic [7:0]    e_byte;
  bit            e_bv, e_sof, e_eof, e_lock, e_inv, e_det;
  logic [EW-1:0] e_err;
  logic [15:0]   e_fcnt;

  function automatic void model_reset();
    m_lock = 0; m_inv = 0;
    hist.delete(); pay.delete();
    e_byte = '0; e_bv = 0; e_sof = 0; e_eof = 0;
    e_lock = 0; e_inv = 0; e_det = 0;
    e_err = '0; e_fcnt = '0;
  endfunction

  function automatic void model_step(bit dv, bit b, bit h);
    logic [31:0] w;
    logic [7:0]  by;
    int d0, d1, n;
    e_bv = 0; e_sof = 0; e_eof = 0; e_det = 0;
    if (h) begin
      m_lock = 0; e_lock = 0;
      hist.delete(); pay.delete();
      return;
    end
    if (!dv) return;
    if (!m_lock) begin
      hist.push_back(b);
      if (hist.size() > SW) void'(hist.pop_front());
      if (hist.size() == SW) begin
        w = '0;
        foreach (hist[i]) w = {w[30:0], hist[i]};
        d0 = $countones(w ^ ASM);
        d1 = $countones(w ^ ~ASM);
        if (d0 <= ME || d1 <= ME) begin
          m_lock = 1;
          m_inv  = (d0 > ME);
          e_inv  = m_inv;
          e_err  = EW'(m_inv ? d1 : d0);
          e_det  = 1;
          e_lock = 1;
          pay.delete();
        end
      end
    end else begin
      pay.push_back(b ^ m_inv);
      if (pay.size() % 8 == 0) begin
        by = '0;
        for (int i = pay.size() - 8; i < pay.size(); i++)
          by = {by[6:0], pay[i]};
        n      = pay.size() / 8 - 1;
        e_byte = by;
        e_bv   = 1;
        e_sof  = (n == 0);
        e_eof  = (n == PB - 1);
        if (n == PB - 1) begin
          m_lock = 0; e_lock = 0;
          hist.delete();
          e_fcnt = e_fcnt + 16'd1;
        end
      end
    end
  endfunction

  // observation log for literal checks
  bit         chk_en = 0;
  logic [7:0] ob_byte[$];
  bit         ob_sof[$];
  bit         ob_eof[$];
  int         ob_det, ob_lock;
  logic [EW-1:0] ob_err;
  bit         ob_inv;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_o", bus.byte_o, e_byte);
      chk("byte_val_o", bus.byte_val_o, e_bv);
      chk("sof_o", bus.sof_o, e_sof);
      chk("eof_o", bus.eof_o, e_eof);
      chk("lock_o", bus.lock_o, e_lock);
      chk("inverted_o", bus.inverted_o, e_inv);
      chk("sync_det_o", bus.sync_det_o, e_det);
      chk("sync_err_o", bus.sync_err_o, e_err);
      chk("frame_cnt_o", bus.frame_cnt_o, e_fcnt);
      if (bus.byte_val_o === 1'b1) begin
        ob_byte.push_back(bus.byte_o);
        ob_sof.push_back(bus.sof_o);
        ob_eof.push_back(bus.eof_o);
      end
      if (bus.sync_det_o === 1'b1) begin
        ob_det++;
        ob_err = bus.sync_err_o;
        ob_inv = bus.inverted_o;
      end
      if (bus.lock_o === 1'b1) ob_lock++;
    end
  end

  task automatic clear_log();
    ob_byte.delete(); ob_sof.delete(); ob_eof.delete();
    ob_det = 0; ob_lock = 0; ob_err = '0; ob_inv = 0;
  endtask

  task automatic tick(bit dv, bit b, bit h);
    bus.data_val_i = dv;
    bus.data_i     = b;
    bus.hunt_i     = h;
    model_step(dv, b, h);
    @(negedge clk);
    #1;
    bus.data_val_i = 1'b0;
    bus.hunt_i     = 1'b0;
  endtask

  task automatic send_bit(bit b, int gap);
    tick(1'b1, b, 1'b0);
    repeat (gap - 1) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(logic [63:0] v, int n,
                           bit inv, int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i] ^ inv, gap);
  endtask

  task automatic send_frame(bit inv, int gap,
                            logic [31:0] flip, bit pre);
    if (pre) send_word({24'h0, PRE}, 40, inv, gap);
    send_word({32'h0, ASM ^ flip}, 32, inv, gap);
    for (int k = 0; k < PB; k++)
      send_word(64'(k), 8, inv, gap);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frames(string nm, int nfr, bit inv,
                              int err, logic [15:0] fcnt);
    int bad;
    bad = 0;
    chk({nm, ".det_cnt"}, 64'(ob_det), 64'(nfr));
    chk({nm, ".sync_err"}, 64'(ob_err), 64'(err));
    chk({nm, ".inverted"}, 64'(ob_inv), 64'(inv));
    chk({nm, ".nbytes"}, 64'(ob_byte.size()), 64'(nfr * PB));
    foreach (ob_byte[i]) begin
      if (ob_byte[i] != 8'(i % PB)) bad++;
      if (ob_sof[i] != (i % PB == 0)) bad++;
      if (ob_eof[i] != (i % PB == PB - 1)) bad++;
    end
    chk({nm, ".byte_seq"}, 64'(bad), 64'd0);
    chk({nm, ".frame_cnt"}, bus.frame_cnt_o, fcnt);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.byte_o, bus.byte_val_o, bus.sof_o,
                bus.eof_o, bus.lock_o, bus.inverted_o,
                bus.sync_det_o, bus.sync_err_o,
                bus.frame_cnt_o});
  endfunction

  initial begin
    int neof;
    bus.data_i     = 1'b0;
    bus.data_val_i = 1'b0;
    bus.hunt_i     = 1'b0;
    reset_n        = 1'b1;
    model_reset();
    clear_log();
    #1 reset_n = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    reset_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // clean frame, slow bit rate
    clear_log();
    send_frame(1'b0, 20, 32'h0, 1'b1);
    check_frames("clean", 1, 1'b0, 0, 16'd1);

    // fully inverted stream
    clear_log();
    send_frame(1'b1, 20, 32'h0, 1'b1);
    check_frames("invert", 1, 1'b1, 0, 16'd2);

    // two flipped sync bits still lock
    clear_log();
    send_frame(1'b0, 2, 32'h0000_0101, 1'b1);
    check_frames("err2", 1, 1'b0, 2, 16'd3);

    // three flipped sync bits never lock
    clear_log();
    send_frame(1'b0, 2, 32'h8000_0101, 1'b1);
    chk("err3.det_cnt", 64'(ob_det), 64'd0);
    chk("err3.lock_cycles", 64'(ob_lock), 64'd0);
    chk("err3.frame_cnt", bus.frame_cnt_o, 16'd3);

    // abort after byte 5 on a coincident data bit
    clear_log();
    send_word({24'h0, PRE}, 40, 1'b0, 2);
    send_word({32'h0, ASM}, 32, 1'b0, 2);
    for (int k = 0; k < 6; k++) send_word(64'(k), 8, 1'b0, 2);
    tick(1'b1, 1'b1, 1'b1);
    chk("abort.lock_next", bus.lock_o, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    neof = 0;
    foreach (ob_eof[i]) neof += ob_eof[i];
    chk("abort.nbytes", 64'(ob_byte.size()), 64'd6);
    chk("abort.no_eof", 64'(neof), 64'd0);
    chk("abort.frame_cnt", bus.frame_cnt_o, 16'd3);
    clear_log();
    send_frame(1'b0, 2, 32'h0, 1'b1);
    check_frames("post_abort", 1, 1'b0, 0, 16'd4);

    // asynchronous reset in the middle of a payload
    clear_log();
    send_word({24'h0, PRE}, 40, 1'b0, 2);
    send_word({32'h0, ASM}, 32, 1'b0, 2);
    for (int k = 0; k < 3; k++) send_word(64'(k), 8, 1'b0, 2);
    send_word(64'h5, 3, 1'b0, 2);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_async", all_outs(), 64'd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // fill guard: 31 trailing sync bits right after reset
    clear_log();
    send_word({32'h0, ASM}, 31, 1'b0, 2);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("fill.no_det", 64'(ob_det), 64'd0);
    send_frame(1'b0, 2, 32'h0, 1'b0);
    check_frames("fill", 1, 1'b0, 0, 16'd1);

    // preload counter, then back-to-back frames across wrap
    force dut.frame_cnt_q = 16'hFFFD;
    e_fcnt = 16'hFFFD;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    release dut.frame_cnt_q;
    tick(1'b0, 1'b0, 1'b0);
    chk("wrap.preload", bus.frame_cnt_o, 16'hFFFD);
    clear_log();
    for (int f = 0; f < 3; f++) begin
      send_word({32'h0, ASM}, 32, 1'b0, 1);
      for (int k = 0; k < PB; k++)
        send_word(64'(k), 8, 1'b0, 1);
      if (f == 1) chk("wrap.ffff", bus.frame_cnt_o, 16'hFFFF);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    check_frames("wrap", 3, 1'b0, 0, 16'h0000);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_frame_sync.md
# msk_frame_sync

Bit-level frame synchronizer for the MSK receive chain. Consumes the hard-decision bit stream from `msk_slicer_dec_mdl` (`data_o`/`data_valid_o`) and hunts for a sync word with a configurable Hamming-distance tolerance. It resolves the 180° bit-polarity ambiguity left by carrier recovery and emits a fixed-length payload as MSB-first bytes with start/end-of-frame markers. It sits between the slicer and the packet/CRC layer.

## Interface

Parameters:
- `SYNC_W`, 32, sync word length in bits (8..64)
- `SYNC_WORD`, 32'h1ACF_FC1D, sync pattern; the first transmitted bit is the MSB
- `MAX_ERR`, 2, maximum bit mismatches accepted; must be < SYNC_W/4
- `PAYLOAD_BYTES`, 16, payload bytes per frame (1..255)
- `EW`, $clog2(SYNC_W+1), width of the error-count output

Ports:
- `clk`  in  1  system clock (200 MHz)
- `reset_n`  in  1  asynchronous active-low reset
- `data_i`  in  1  sliced bit
- `data_val_i`  in  1  qualifies `data_i`; at most one bit per clock
- `hunt_i`  in  1  synchronous abort; force return to HUNT
- `byte_o`  out  8  payload byte, polarity corrected, MSB = first bit received
- `byte_val_o`  out  1  one-cycle strobe qualifying `byte_o`
- `sof_o`  out  1  high with `byte_val_o` on the first payload byte
- `eof_o`  out  1  high with `byte_val_o` on the last payload byte
- `lock_o`  out  1  high while in the PAYLOAD state
- `inverted_o`  out  1  polarity of the current or last frame (1 = inverted sync matched)
- `sync_det_o`  out  1  one-cycle pulse on sync acceptance
- `sync_err_o`  out  EW  mismatch count of the accepted sync; held until the next detection
- `frame_cnt_o`  out  16  completed frames; wraps at 0xFFFF→0

## Operation

- States: HUNT and PAYLOAD. Reset enters HUNT.
- Shift register `sr[SYNC_W-1:0]`: on `data_val_i`, `sr <= {sr[SYNC_W-2:0], data_i}`. Loads in both states.
- Fill counter: saturates at SYNC_W and is cleared on entry to HUNT. No match is evaluated until at least SYNC_W bits have been shifted since entering HUNT, counting the current bit.
- HUNT: on each `data_val_i`, compute two distances on the updated register value:
  - `d0 = popcount(sr_next ^ SYNC_WORD)`
  - `d1 = popcount(sr_next ^ ~SYNC_WORD)`
- Match handling:
  - If `d0 <= MAX_ERR`: accept with inv=0 and `sync_err_o = d0`.
  - Otherwise, if `d1 <= MAX_ERR`: accept with inv=1 and `sync_err_o = d1`.
  - On acceptance: go to PAYLOAD, pulse `sync_det_o`, latch `inverted_o`, clear the bit and byte counters.
- PAYLOAD:
  - Each `data_val_i` bit is XORed with inv and shifted into the byte register MSB-first.
  - On the 8th bit: present the byte, pulse `byte_val_o`, and increment the byte counter.
  - Byte 0 asserts `sof_o`; byte PAYLOAD_BYTES-1 asserts `eof_o` (both are asserted when PAYLOAD_BYTES=1).
  - After the last byte: return to HUNT, clear the fill counter, increment `frame_cnt_o`.
- `hunt_i` is valid in any state:
  - Returns to HUNT and clears the fill, bit and byte counters.
  - Any partial byte is dropped; no `eof_o`; `frame_cnt_o` is unchanged.
  - If asserted in the same cycle as `data_val_i`, `hunt_i` wins and that bit is discarded, not shifted.
- Sync bits are never emitted as payload.
- The first bit after the matching bit is payload bit 0.

## Timing

- Reset values: every output is 0, state = HUNT, all counters and registers are 0. Reset may assert mid-frame; no eof is produced.
- All outputs are registered.
- Sync latency: bit completing the sync at cycle N → `sync_det_o`, `lock_o`, `inverted_o`, `sync_err_o` valid at N+1.
- Byte latency: 8th bit at cycle N → `byte_o`/`byte_val_o`/`sof_o`/`eof_o` at N+1. `byte_o` holds until the next byte.
- `lock_o` drops at N+1 after the last-byte bit, coincident with `eof_o`. `frame_cnt_o` updates in the same cycle.
- `hunt_i` at N → `lock_o` = 0 at N+1.
- No backpressure: the downstream consumer must accept every `byte_val_o`.
- Back-to-back frames: the next sync needs SYNC_W new bits after frame end. Bits arriving during PAYLOAD do not count toward it.

## Test plan

- Clean frame: 40 random bits, then 0x1ACFFC1D, then 16 bytes 0x00..0x0F, at one bit every 20 clocks → `sync_det_o` once with `sync_err_o`=0 and `inverted_o`=0; bytes 0x00..0x0F with `sof_o` on 0x00 and `eof_o` on 0x0F; `frame_cnt_o`=1.
- Inverted polarity: the same stream fully bit-inverted → identical payload bytes 0x00..0x0F, `inverted_o`=1, `sync_err_o`=0.
- Error tolerance: sync with 2 flipped bits → lock with `sync_err_o`=2. Sync with 3 flipped bits → no `sync_det_o`, `lock_o` stays 0.
- Fill guard: immediately after reset, shift only the last 31 bits of the sync pattern → no detection. Then a full sync → detection.
- Abort: `hunt_i` pulsed after byte 5, coincident with a `data_val_i` → `lock_o` 0 next cycle, no `eof_o`, `frame_cnt_o` unchanged. A following clean frame decodes correctly.
- Back-to-back frames and wrap: 3 consecutive frames with `frame_cnt_o` preloaded by running 65535 frames (or forced) → count wraps to 0, and each frame's `sof_o`/`eof_o` pairs correctly. Also assert `reset_n` mid-payload → all outputs 0 asynchronously.
